// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared types and default sizing for the interrupt encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int N_DEF = 8;
    localparam int W_DEF = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/irq_encoder_prio.sv
`default_nettype none
// ============================================================================
// Module      : prio_encoder
// Description : Combinational index of the highest set bit plus an any-set flag.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_encoder
    import irq_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic [N-1:0] in,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan: the last hit, i.e. the highest index, wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (in[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |in;

endmodule
`default_nettype wire

// File: rtl/irq_encoder.sv
`default_nettype none
// ============================================================================
// Module      : irq_encoder
// Description : Edge-captured sticky pending register feeding a registered
//               priority encoder held under a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_encoder
    import irq_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] REQ_N,
    input  logic         EN_N,
    input  logic         ACK,
    output logic         VALID,
    output logic [W-1:0] CODE,
    output logic         GS_N,
    output logic [N-1:0] PEND
);

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_req_prev;
    logic [N-1:0]   r_pend;
    logic           r_valid;
    logic [W-1:0]   r_code;
    logic           r_gs_n;

    logic [N-1:0]   w_set;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_pend_next;
    logic           w_valid_next;
    logic [W-1:0]   w_code_next;
    logic [W-1:0]   w_idx;
    logic           w_any;

    prio_encoder #(
        .N (N),
        .W (W)
    ) u_prio (
        .in  (r_pend),
        .idx (w_idx),
        .any (w_any)
    );

    // Falling edge on a request line; set is applied after clear so a
    // coincident re-request on the retired source survives.
    assign w_set       = r_req_prev & ~REQ_N;
    assign w_pend_next = (r_pend & ~w_clr) | w_set;

    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_valid;
        w_code_next  = r_code;
        w_clr        = '0;
        case (r_state)
            IDLE: begin
                if (!EN_N && w_any) begin
                    w_state_next = GRANT;
                    w_valid_next = 1'b1;
                    w_code_next  = w_idx;
                end
            end
            GRANT: begin
                if (ACK) begin
                    w_clr[r_code] = 1'b1;
                    w_valid_next  = 1'b0;
                    w_state_next  = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req_prev <= '1;
            r_pend     <= '0;
            r_valid    <= 1'b0;
            r_code     <= '0;
            r_gs_n     <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_req_prev <= REQ_N;
            r_pend     <= w_pend_next;
            r_valid    <= w_valid_next;
            r_code     <= w_code_next;
            r_gs_n     <= ~|w_pend_next;
        end
    end

    assign VALID = r_valid;
    assign CODE  = r_code;
    assign GS_N  = r_gs_n;
    assign PEND  = r_pend;

endmodule
`default_nettype wire
